fetch_channel_arbiter: RTL and testbench

- Shares NUM_CHANNELS program-memory read channels among NUM_CONSUMERS fetchers, with round-robin fairness.
- Sits between the per-logical-core fetcher buses and the external program memory.
- Each channel runs its own request/relay/release FSM.
- A consumer is owned by at most one channel at a time.

---
 rtl/fetch_channel_arbiter.sv | 135 +++++++++++++
 tb/tb_fetch_channel_arbiter.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/fetch_channel_arbiter.sv
// fetch_channel_arbiter: round-robin sharing of NUM_CHANNELS program-memory read channels among NUM_CONSUMERS fetchers.
// Define FETCH_ARB_BROADCAST_EN to serve every same-address requester from one memory response.
module fetch_channel_arbiter #(
    parameter int NUM_CONSUMERS = 4,
    parameter int NUM_CHANNELS  = 1,
    parameter int ADDR_BITS     = 8,
    parameter int DATA_BITS     = 16
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [NUM_CONSUMERS-1:0]           consumer_read_valid,
    input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_read_address,
    output logic [NUM_CONSUMERS-1:0]           consumer_read_ready,
    output logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_read_data,
    output logic [NUM_CHANNELS-1:0]            mem_read_valid,
    output logic [NUM_CHANNELS*ADDR_BITS-1:0]  mem_read_address,
    input  logic [NUM_CHANNELS-1:0]            mem_read_ready,
    input  logic [NUM_CHANNELS*DATA_BITS-1:0]  mem_read_data,
    output logic                               busy
);
    localparam int CW = $clog2(NUM_CONSUMERS);

    typedef enum logic [1:0] {IDLE, WAIT_MEM, RELAY, WAIT_RELEASE} state_t;

    state_t                     state   [NUM_CHANNELS];
    state_t                     state_n [NUM_CHANNELS];
    logic [NUM_CONSUMERS-1:0]   mask    [NUM_CHANNELS];
    logic [NUM_CONSUMERS-1:0]   mask_n  [NUM_CHANNELS];
    logic [NUM_CONSUMERS-1:0]   owned, owned_n, taken, served, ready_n;
    logic [CW-1:0]              rr_ptr, rr_n, idx, pick;
    logic [CW:0]                sum;
    logic                       found, busy_n;
    logic [NUM_CHANNELS-1:0]    mvalid_n;
    logic [NUM_CHANNELS*ADDR_BITS-1:0]  maddr_n;
    logic [NUM_CONSUMERS*DATA_BITS-1:0] data_n;

    always_comb begin
        state_n  = state;
        mask_n   = mask;
        owned_n  = owned;
        taken    = owned;
        served   = '0;
        ready_n  = '0;
        rr_n     = rr_ptr;
        mvalid_n = mem_read_valid;
        maddr_n  = mem_read_address;
        data_n   = consumer_read_data;
        found    = 1'b0;
        pick     = '0;
        idx      = '0;
        sum      = '0;
        busy_n   = 1'b0;
        // Responses and releases first, so grants see every consumer served this cycle
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            served = mask[c];
            if (state[c] == WAIT_MEM && mem_read_ready[c]) begin
`ifdef FETCH_ARB_BROADCAST_EN
                for (int j = 0; j < NUM_CONSUMERS; j++)
                    if (consumer_read_valid[j] && !taken[j] &&
                        consumer_read_address[j*ADDR_BITS +: ADDR_BITS] == mem_read_address[c*ADDR_BITS +: ADDR_BITS])
                        served[j] = 1'b1;
                taken   = taken | served;
                owned_n = owned_n | served;
`endif
                for (int j = 0; j < NUM_CONSUMERS; j++)
                    if (served[j])
                        data_n[j*DATA_BITS +: DATA_BITS] = mem_read_data[c*DATA_BITS +: DATA_BITS];
                ready_n     = ready_n | served;
                mask_n[c]   = served;
                mvalid_n[c] = 1'b0;
                state_n[c]  = RELAY;
            end else if (state[c] == RELAY) begin
                state_n[c] = WAIT_RELEASE;
            end else if (state[c] == WAIT_RELEASE) begin
                mask_n[c] = mask[c] & consumer_read_valid;
                owned_n   = owned_n & ~(mask[c] & ~consumer_read_valid);
                state_n[c] = ((mask[c] & consumer_read_valid) == '0) ? IDLE : WAIT_RELEASE;
            end
        end
        // Ascending channel order; the last grant leaves rr_ptr after the highest channel's pick
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            if (state[c] == IDLE) begin
                found = 1'b0;
                pick  = '0;
                for (int i = 0; i < NUM_CONSUMERS; i++) begin
                    sum = {1'b0, rr_ptr} + (CW+1)'(i);
                    sum = (sum >= (CW+1)'(NUM_CONSUMERS)) ? sum - (CW+1)'(NUM_CONSUMERS) : sum;
                    idx = sum[CW-1:0];
                    if (!found && consumer_read_valid[idx] && !taken[idx]) begin
                        found = 1'b1;
                        pick  = idx;
                    end
                end
                if (found) begin
                    taken[pick]   = 1'b1;
                    owned_n[pick] = 1'b1;
                    mask_n[c]       = '0;
                    mask_n[c][pick] = 1'b1;
                    maddr_n[c*ADDR_BITS +: ADDR_BITS] = consumer_read_address[pick*ADDR_BITS +: ADDR_BITS];
                    mvalid_n[c] = 1'b1;
                    state_n[c]  = WAIT_MEM;
                    rr_n = (pick == CW'(NUM_CONSUMERS-1)) ? '0 : pick + 1'b1;
                end
            end
        end
        for (int c = 0; c < NUM_CHANNELS; c++)
            busy_n = busy_n | (state_n[c] != IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                state[c] <= IDLE;
                mask[c]  <= '0;
            end
            owned               <= '0;
            rr_ptr              <= '0;
            consumer_read_ready <= '0;
            consumer_read_data  <= '0;
            mem_read_valid      <= '0;
            mem_read_address    <= '0;
            busy                <= 1'b0;
        end else begin
            state               <= state_n;
            mask                <= mask_n;
            owned               <= owned_n;
            rr_ptr              <= rr_n;
            consumer_read_ready <= ready_n;
            consumer_read_data  <= data_n;
            mem_read_valid      <= mvalid_n;
            mem_read_address    <= maddr_n;
            busy                <= busy_n;
        end
    end
endmodule

// File: tb/tb_fetch_channel_arbiter.sv
// tb_fetch_channel_arbiter: directed checks of a 1-channel and a 2-channel arbiter instance.
module tb_fetch_channel_arbiter;
    logic        clk = 1'b0;
    logic        reset = 1'b0;

    logic [3:0]  v1 = '0, r1;
    logic [31:0] a1 = '0;
    logic [63:0] d1;
    logic [0:0]  mv1, mr1 = '0;
    logic [7:0]  ma1;
    logic [15:0] md1 = '0;
    logic        busy1;

    logic [3:0]  v2 = '0, r2;
    logic [31:0] a2 = '0;
    logic [63:0] d2;
    logic [1:0]  mv2, mr2 = '0;
    logic [15:0] ma2;
    logic [31:0] md2 = '0;
    logic        busy2;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    fetch_channel_arbiter #(.NUM_CONSUMERS(4), .NUM_CHANNELS(1), .ADDR_BITS(8), .DATA_BITS(16)) u1 (
        .clk(clk), .reset(reset),
        .consumer_read_valid(v1), .consumer_read_address(a1),
        .consumer_read_ready(r1), .consumer_read_data(d1),
        .mem_read_valid(mv1), .mem_read_address(ma1),
        .mem_read_ready(mr1), .mem_read_data(md1), .busy(busy1));

    fetch_channel_arbiter #(.NUM_CONSUMERS(4), .NUM_CHANNELS(2), .ADDR_BITS(8), .DATA_BITS(16)) u2 (
        .clk(clk), .reset(reset),
        .consumer_read_valid(v2), .consumer_read_address(a2),
        .consumer_read_ready(r2), .consumer_read_data(d2),
        .mem_read_valid(mv2), .mem_read_address(ma2),
        .mem_read_ready(mr2), .mem_read_data(md2), .busy(busy2));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        tick();
        tick();
        chk("rst_ready1", 64'(r1), 64'h0);
        chk("rst_mvalid1", 64'(mv1), 64'h0);
        chk("rst_busy1", 64'(busy1), 64'h0);
        chk("rst_data1", d1, 64'h0);
        chk("rst_mvalid2", 64'(mv2), 64'h0);
        reset = 1'b1;

        // single request from consumer 2
        v1 = 4'b0100;
        a1[23:16] = 8'h10;
        tick();
        chk("single_mvalid", 64'(mv1), 64'h1);
        chk("single_addr", 64'(ma1), 64'h10);
        chk("single_busy", 64'(busy1), 64'h1);
        tick();
        chk("single_hold", 64'(mv1), 64'h1);
        chk("single_noready", 64'(r1), 64'h0);
        mr1 = 1'b1;
        md1 = 16'hBEEF;
        tick();
        mr1 = 1'b0;
        chk("single_ready", 64'(r1), 64'h4);
        chk("single_data", 64'(d1[47:32]), 64'hBEEF);
        chk("single_mdrop", 64'(mv1), 64'h0);
        tick();
        chk("single_pulse_end", 64'(r1), 64'h0);
        chk("single_busy_wait", 64'(busy1), 64'h1);
        v1 = 4'b0000;
        tick();
        chk("single_idle", 64'(busy1), 64'h0);

        // fairness: restart from rr_ptr=0, all consumers requesting
        reset = 1'b0;
        tick();
        reset = 1'b1;
        a1 = 32'h43424140;
        v1 = 4'b1111;
        for (int n = 0; n < 5; n++) begin
            tick();
            chk($sformatf("fair_addr%0d", n), 64'(ma1), 64'(8'h40 + 8'(n % 4)));
            mr1 = 1'b1;
            md1 = 16'h1000 + 16'(n);
            tick();
            mr1 = 1'b0;
            chk($sformatf("fair_ready%0d", n), 64'(r1), 64'(4'b0001 << (n % 4)));
            v1[n % 4] = 1'b0;
            tick();
            tick();
            v1[n % 4] = 1'b1;
        end

        // two channels, consumers 1 and 3 together
        a2 = 32'h33221100;
        v2 = 4'b1010;
        tick();
        chk("dual_mvalid", 64'(mv2), 64'h3);
        chk("dual_addr", 64'(ma2), 64'h3311);
        mr2 = 2'b11;
        md2 = 32'h3333_1111;
        tick();
        mr2 = 2'b00;
        v2 = 4'b0000;
        chk("dual_ready", 64'(r2), 64'hA);
        chk("dual_data3", 64'(d2[63:48]), 64'h3333);
        chk("dual_data1", 64'(d2[31:16]), 64'h1111);
        tick();
        tick();
        chk("dual_idle", 64'(busy2), 64'h0);
        v2 = 4'b1111;
        tick();
        chk("dual_rr_wrap", 64'(ma2), 64'h1100);

        // reset while channel 0 waits for memory
        v1 = 4'b0001;
        a1 = 32'h0000_0055;
        tick();
        chk("rstmid_mvalid", 64'(mv1), 64'h1);
        reset = 1'b0;
        #1;
        chk("rstmid_mvalid0", 64'(mv1), 64'h0);
        chk("rstmid_ready0", 64'(r1), 64'h0);
        chk("rstmid_busy0", 64'(busy1), 64'h0);
        tick();
        reset = 1'b1;
        v1 = 4'b0000;
        v2 = 4'b0000;
        mr1 = 1'b1;
        md1 = 16'h1234;
        tick();
        mr1 = 1'b0;
        chk("rstmid_noready", 64'(r1), 64'h0);
        chk("rstmid_nomem", 64'(mv1), 64'h0);
        tick();

        // consumers 0 and 2 share address 0x20
        v1 = 4'b0101;
        a1 = 32'h0020_0020;
        tick();
        chk("bc_mvalid", 64'(mv1), 64'h1);
        chk("bc_addr", 64'(ma1), 64'h20);
        mr1 = 1'b1;
        md1 = 16'hCAFE;
        tick();
        mr1 = 1'b0;
`ifdef FETCH_ARB_BROADCAST_EN
        chk("bc_ready_both", 64'(r1), 64'h5);
        chk("bc_data0", 64'(d1[15:0]), 64'hCAFE);
        chk("bc_data2", 64'(d1[47:32]), 64'hCAFE);
        v1 = 4'b0000;
        tick();
        tick();
        tick();
        chk("bc_single_txn", 64'(mv1), 64'h0);
        chk("bc_idle", 64'(busy1), 64'h0);
`else
        chk("bc_ready_first", 64'(r1), 64'h1);
        chk("bc_data0", 64'(d1[15:0]), 64'hCAFE);
        v1[0] = 1'b0;
        tick();
        tick();
        tick();
        chk("bc_second_mvalid", 64'(mv1), 64'h1);
        chk("bc_second_addr", 64'(ma1), 64'h20);
        mr1 = 1'b1;
        md1 = 16'hD00D;
        tick();
        mr1 = 1'b0;
        chk("bc_ready_second", 64'(r1), 64'h4);
        chk("bc_data2", 64'(d1[47:32]), 64'hD00D);
        chk("bc_data0_hold", 64'(d1[15:0]), 64'hCAFE);
        v1 = 4'b0000;
        tick();
        tick();
        chk("bc_idle", 64'(busy1), 64'h0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
